phy_tx_serializer: RTL

//  Two-lane transmit end of the serial link: pops bytes from two upstream FIFOs and shifts each out MSB-first, one bit per clk.

---
 rtl/phy_tx_serializer_pkg.sv | 10 +
 rtl/phy_tx_serializer_lane_serializer.sv | 98 +++++++++
 rtl/phy_tx_serializer.sv | 67 ++++++
 3 files changed

// File: rtl/phy_tx_serializer_pkg.sv
// Shared constants for the two-lane transmit serializer: default word size,
// line symbols and lane state encoding.
package phy_tx_serializer_pkg;
   localparam int         DATA_SIZE_DEF  = 8;
   localparam int         SYNC_WORDS_DEF = 4;
   localparam logic [7:0] COMMA_SYM      = 8'hBC;
   localparam logic [7:0] IDLE_SYM       = 8'h7C;
   localparam logic [0:0] ST_SYNC        = 1'b0;
   localparam logic [0:0] ST_ACTIVE      = 1'b1;
endpackage

// File: rtl/phy_tx_serializer_lane_serializer.sv
// One serial lane (lane_serializer): bit counter, SYNC/ACTIVE FSM, shift register and FIFO pop.
// Optional o_active output when TX_ACTIVE_OUT_EN is defined.
module phy_tx_serializer_lane_serializer
   import phy_tx_serializer_pkg::*;
#(
   parameter int                   DATA_SIZE  = DATA_SIZE_DEF,
   parameter int                   SYNC_WORDS = SYNC_WORDS_DEF,
   parameter logic [DATA_SIZE-1:0] COMMA      = COMMA_SYM,
   parameter logic [DATA_SIZE-1:0] IDLE       = IDLE_SYM
) (
   input  logic                 clk,
   input  logic                 i_rst_n,
   input  logic                 i_tx_en,
   input  logic [DATA_SIZE-1:0] i_data,
   input  logic                 i_empty,
   output logic                 o_pop,
   output logic                 o_out
`ifdef TX_ACTIVE_OUT_EN
   ,
   output logic                 o_active
`endif
);

   localparam int             CW       = $clog2(DATA_SIZE);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_SIZE - 1);
   localparam logic [CW-1:0]  CNT_POP  = CW'(DATA_SIZE - 2);
   localparam logic [3:0]     SCNT_TGT = 4'(SYNC_WORDS);

   logic [CW-1:0]        r_cnt;
   logic [DATA_SIZE-1:0] r_shreg;
   logic [0:0]           r_state;
   logic [3:0]           r_scnt;
   logic                 r_popped;

   logic                 w_last;
   logic                 w_pop;
   logic [0:0]           w_next_state;
   logic [3:0]           w_next_scnt;
   logic [DATA_SIZE-1:0] w_next_word;

   // FIFO handshake: o_pop is a one-cycle read strobe; i_data holds the popped
   // byte in the following cycle, which is always the word-boundary cycle.
   assign w_last = (r_cnt == CNT_LAST);
   assign w_pop  = (r_cnt == CNT_POP) && (r_state == ST_ACTIVE) && i_tx_en && !i_empty;
   assign o_pop  = w_pop;
   assign o_out  = r_shreg[DATA_SIZE-1];

   always_comb begin
      w_next_state = r_state;
      w_next_scnt  = r_scnt;
      w_next_word  = COMMA;
      if (r_state == ST_SYNC) begin
         if (!i_tx_en) begin
            w_next_scnt = '0;
         end else if (r_scnt + 4'd1 == SCNT_TGT) begin
            w_next_state = ST_ACTIVE;
            w_next_scnt  = '0;
         end else begin
            w_next_scnt = r_scnt + 4'd1;
         end
      end else if (!i_tx_en) begin
         w_next_state = ST_SYNC;
         w_next_scnt  = '0;
      end
      // Filler follows the state being entered, so the last COMMA is followed by IDLE.
      if (r_popped) begin
         w_next_word = i_data;
      end else if (w_next_state == ST_ACTIVE) begin
         w_next_word = IDLE;
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_shreg  <= COMMA;
         r_state  <= ST_SYNC;
         r_scnt   <= '0;
         r_popped <= 1'b0;
      end else begin
         r_popped <= w_pop;
         if (w_last) begin
            r_cnt   <= '0;
            r_shreg <= w_next_word;
            r_state <= w_next_state;
            r_scnt  <= w_next_scnt;
         end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_shreg <= {r_shreg[DATA_SIZE-2:0], 1'b0};
         end
      end
   end

`ifdef TX_ACTIVE_OUT_EN
   assign o_active = (r_state == ST_ACTIVE);
`endif

endmodule

// File: rtl/phy_tx_serializer.sv
// Two-lane transmit serializer: two independent lanes sharing clk, reset and tx_en.
// Define TX_ACTIVE_OUT_EN to add the active0/active1 lane-state outputs.
module phy_tx_serializer
   import phy_tx_serializer_pkg::*;
#(
   parameter int                   DATA_SIZE  = DATA_SIZE_DEF,
   parameter int                   SYNC_WORDS = SYNC_WORDS_DEF,
   parameter logic [DATA_SIZE-1:0] COMMA      = COMMA_SYM,
   parameter logic [DATA_SIZE-1:0] IDLE       = IDLE_SYM
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_en,
   input  logic [DATA_SIZE-1:0] data0,
   input  logic                 empty0,
   input  logic [DATA_SIZE-1:0] data1,
   input  logic                 empty1,
   output logic                 pop0,
   output logic                 pop1,
   output logic                 out0,
   output logic                 out1
`ifdef TX_ACTIVE_OUT_EN
   ,
   output logic                 active0,
   output logic                 active1
`endif
);

   phy_tx_serializer_lane_serializer #(
      .DATA_SIZE  (DATA_SIZE),
      .SYNC_WORDS (SYNC_WORDS),
      .COMMA      (COMMA),
      .IDLE       (IDLE)
   ) u_lane0 (
      .clk      (clk),
      .i_rst_n  (reset),
      .i_tx_en  (tx_en),
      .i_data   (data0),
      .i_empty  (empty0),
      .o_pop    (pop0),
      .o_out    (out0)
`ifdef TX_ACTIVE_OUT_EN
      ,
      .o_active (active0)
`endif
   );

   phy_tx_serializer_lane_serializer #(
      .DATA_SIZE  (DATA_SIZE),
      .SYNC_WORDS (SYNC_WORDS),
      .COMMA      (COMMA),
      .IDLE       (IDLE)
   ) u_lane1 (
      .clk      (clk),
      .i_rst_n  (reset),
      .i_tx_en  (tx_en),
      .i_data   (data1),
      .i_empty  (empty1),
      .o_pop    (pop1),
      .o_out    (out1)
`ifdef TX_ACTIVE_OUT_EN
      ,
      .o_active (active1)
`endif
   );

endmodule
